// File: rtl/draw_pkg.sv
// draw_pkg: shared arbitration constants, FSM state type and 320x240 / 3-bit colour defaults
// for the VGA draw-port arbiter.
package draw_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int DEF_X_W   = 9;
    localparam int DEF_Y_W   = 9;
    localparam int DEF_CLR_W = 3;
    localparam int DEF_X_MAX = 319;
    localparam int DEF_Y_MAX = 239;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/draw_arb_pick.sv
// draw_arb_pick: combinational one-hot request picker, fixed priority (ch0 first) or
// round-robin starting at rr_ptr.
module draw_arb_pick #(
    parameter int NUM_CH = 5,
    parameter int PW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     rr_ptr,
    input  logic              rr_mode,
    output logic [NUM_CH-1:0] win_oh,
    output logic [PW-1:0]     win_idx
);

    always_comb begin
        int base;
        int idx;
        win_oh  = '0;
        win_idx = '0;
        base    = rr_mode ? int'(rr_ptr) : 0;
        idx     = 0;
        // Walk from the farthest offset back to the start so the nearest requester wins last.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = base + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (req[idx]) begin
                win_oh      = '0;
                win_oh[idx] = 1'b1;
                win_idx     = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter: grants the single VGA pixel-write port to one drawing engine per burst
// and forwards its pixels through a clipped, registered output stage.
module draw_port_arbiter
    import draw_pkg::*;
#(
    parameter int NUM_CH   = 5,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int CLR_W    = DEF_CLR_W,
    parameter int X_MAX    = DEF_X_MAX,
    parameter int Y_MAX    = DEF_Y_MAX,
    parameter int ARB_MODE = ARB_FIXED,
    parameter int TIMEOUT  = 1023,
    parameter int IDLE_CLR = 0
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic [NUM_CH-1:0]       req,
    input  logic [NUM_CH-1:0]       pix_valid,
    input  logic [NUM_CH-1:0]       pix_last,
    input  logic [NUM_CH*X_W-1:0]   pix_x,
    input  logic [NUM_CH*Y_W-1:0]   pix_y,
    input  logic [NUM_CH*CLR_W-1:0] pix_clr,
    output logic [NUM_CH-1:0]       grant,
    output logic [NUM_CH-1:0]       pix_ready,
    output logic                    plot,
    output logic [X_W-1:0]          x,
    output logic [Y_W-1:0]          y,
    output logic [CLR_W-1:0]        colour,
    output logic                    busy,
    output logic                    burst_done,
    output logic                    timeout_err
);

    localparam int PW = $clog2(NUM_CH);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [X_W-1:0]   XM       = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   YM       = Y_W'(Y_MAX);
    localparam logic [CLR_W-1:0] CLR_IDLE = CLR_W'(IDLE_CLR);
    localparam logic [CW-1:0]    TO_CNT   = CW'(TIMEOUT);

    arb_state_t          state_q, state_d;
    logic [NUM_CH-1:0]   grant_q, grant_d;
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       idle_cnt_q, idle_cnt_d;
    logic                plot_q, plot_d;
    logic                done_q, done_d;
    logic                terr_q, terr_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [CLR_W-1:0]    colour_q, colour_d;

    logic [NUM_CH-1:0]   win_oh;
    logic [PW-1:0]       win_idx;
    logic [X_W-1:0]      own_x;
    logic [Y_W-1:0]      own_y;
    logic [CLR_W-1:0]    own_clr;
    logic                own_req, acc, acc_last, in_bounds;

    draw_arb_pick #(
        .NUM_CH (NUM_CH),
        .PW     (PW)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .rr_mode (ARB_MODE == ARB_RR),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_comb begin
        own_x   = '0;
        own_y   = '0;
        own_clr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q[i]) begin
                own_x   = pix_x[i*X_W +: X_W];
                own_y   = pix_y[i*Y_W +: Y_W];
                own_clr = pix_clr[i*CLR_W +: CLR_W];
            end
        end
    end

    assign own_req   = |(req & grant_q);
    assign acc       = |(pix_valid & grant_q);
    assign acc_last  = |(pix_valid & pix_last & grant_q);
    assign in_bounds = (own_x <= XM) && (own_y <= YM);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        terr_d     = terr_q;
        done_d     = 1'b0;
        plot_d     = 1'b0;
        if (state_q == IDLE) begin
            idle_cnt_d = '0;
            if (|req) begin
                state_d  = BURST;
                grant_d  = win_oh;
                rr_ptr_d = (win_idx == PW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
            end
        end else if (acc_last) begin
            // A last pixel completes normally even if req falls in the same cycle.
            state_d = IDLE;
            grant_d = '0;
            done_d  = 1'b1;
            plot_d  = in_bounds;
        end else if (!own_req) begin
            state_d = IDLE;
            grant_d = '0;
        end else if (acc) begin
            idle_cnt_d = '0;
            plot_d     = in_bounds;
        end else begin
            idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_cnt_q + 1'b1;
            if (TIMEOUT != 0 && idle_cnt_d == TO_CNT) begin
                state_d = IDLE;
                grant_d = '0;
                terr_d  = 1'b1;
            end
        end
        x_d      = plot_d ? own_x : x_q;
        y_d      = plot_d ? own_y : y_q;
        colour_d = plot_d ? own_clr : CLR_IDLE;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            plot_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= CLR_IDLE;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            plot_q     <= plot_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
        end
    end

    assign grant       = grant_q;
    assign pix_ready   = grant_q;
    assign plot        = plot_q;
    assign x           = x_q;
    assign y           = y_q;
    assign colour      = colour_q;
    assign busy        = (state_q == BURST);
    assign burst_done  = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_draw_port_arbiter.sv
// tb_draw_port_arbiter: directed bench with an output scoreboard for a fixed-priority
// instance and a grant-order scoreboard for a round-robin instance.
module tb_draw_port_arbiter;

    logic        CLOCK_50;
    logic        resetn;

    logic [4:0]  req_f, pix_valid_f, pix_last_f, grant_f, pix_ready_f;
    logic [44:0] pix_x_f, pix_y_f;
    logic [14:0] pix_clr_f;
    logic        plot_f, busy_f, done_f, terr_f;
    logic [8:0]  x_f, y_f;
    logic [2:0]  colour_f;

    logic [4:0]  req_r, pix_valid_r, pix_last_r, grant_r, pix_ready_r, prev_r;
    logic [44:0] pix_x_r, pix_y_r;
    logic [14:0] pix_clr_r;
    logic        plot_r, busy_r, done_r, terr_r;
    logic [8:0]  x_r, y_r;
    logic [2:0]  colour_r;

    int errors = 0;
    int checks = 0;

    typedef struct {bit done; int x; int y; int c;} ev_t;
    ev_t exp_q[$];
    int  exp_rr[$];

    draw_port_arbiter #(.ARB_MODE(0), .TIMEOUT(8), .IDLE_CLR(7)) u_fix (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .req(req_f), .pix_valid(pix_valid_f),
        .pix_last(pix_last_f), .pix_x(pix_x_f), .pix_y(pix_y_f), .pix_clr(pix_clr_f),
        .grant(grant_f), .pix_ready(pix_ready_f), .plot(plot_f), .x(x_f), .y(y_f),
        .colour(colour_f), .busy(busy_f), .burst_done(done_f), .timeout_err(terr_f)
    );

    draw_port_arbiter #(.ARB_MODE(1), .TIMEOUT(8)) u_rr (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .req(req_r), .pix_valid(pix_valid_r),
        .pix_last(pix_last_r), .pix_x(pix_x_r), .pix_y(pix_y_r), .pix_clr(pix_clr_r),
        .grant(grant_r), .pix_ready(pix_ready_r), .plot(plot_r), .x(x_r), .y(y_r),
        .colour(colour_r), .busy(busy_r), .burst_done(done_r), .timeout_err(terr_r)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_pix(input int px, input int py, input int pc);
        exp_q.push_back('{done: 1'b0, x: px, y: py, c: pc});
    endtask

    task automatic push_done();
        exp_q.push_back('{done: 1'b1, x: 0, y: 0, c: 0});
    endtask

    task automatic drive_f(input int ch, input int px, input int py, input int pc, input bit l);
        pix_valid_f = '0;
        pix_last_f  = '0;
        pix_valid_f[ch] = 1'b1;
        pix_last_f[ch]  = l;
        pix_x_f[ch*9 +: 9]   = 9'(px);
        pix_y_f[ch*9 +: 9]   = 9'(py);
        pix_clr_f[ch*3 +: 3] = 3'(pc);
    endtask

    task automatic idle_f();
        pix_valid_f = '0;
        pix_last_f  = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_grant"}, int'(grant_f), 0);
        chk({tag, "_plot"}, int'(plot_f), 0);
        chk({tag, "_x"}, int'(x_f), 0);
        chk({tag, "_y"}, int'(y_f), 0);
        chk({tag, "_colour"}, int'(colour_f), 7);
        chk({tag, "_busy"}, int'(busy_f), 0);
        chk({tag, "_done"}, int'(done_f), 0);
        chk({tag, "_terr"}, int'(terr_f), 0);
    endtask

    always @(negedge CLOCK_50) begin
        ev_t e;
        if (resetn) begin
            if (plot_f) begin
                if (exp_q.size() == 0) chk("unexpected_plot_x", int'(x_f), -1);
                else begin
                    e = exp_q.pop_front();
                    chk("plot_kind", 0, int'(e.done));
                    chk("plot_x", int'(x_f), e.x);
                    chk("plot_y", int'(y_f), e.y);
                    chk("plot_colour", int'(colour_f), e.c);
                end
            end
            if (done_f) begin
                if (exp_q.size() == 0) chk("unexpected_burst_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("done_kind", 1, int'(e.done));
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (resetn && grant_r != 0 && grant_r != prev_r) begin
            if (exp_rr.size() == 0) chk("unexpected_rr_grant", int'(grant_r), 0);
            else chk("rr_grant", int'(grant_r), 1 << exp_rr.pop_front());
        end
        prev_r <= grant_r;
    end

    initial begin
        int n;
        resetn = 1'b0;
        req_f = '0; pix_valid_f = '0; pix_last_f = '0;
        pix_x_f = '0; pix_y_f = '0; pix_clr_f = '0;
        req_r = '0; pix_valid_r = '0; pix_last_r = '0;
        pix_x_r = {5{9'd7}}; pix_y_r = {5{9'd9}}; pix_clr_r = {5{3'd1}};
        repeat (3) @(negedge CLOCK_50);
        chk_reset("rst");
        resetn = 1'b1;
        @(negedge CLOCK_50);
        chk("idle_busy", int'(busy_f), 0);

        // Fixed priority: ch1 beats ch2 and ch4
        req_f = 5'b10110;
        @(negedge CLOCK_50);
        chk("fp_grant1", int'(grant_f), 5'b00010);
        chk("fp_ready1", int'(pix_ready_f), 5'b00010);
        chk("fp_busy1", int'(busy_f), 1);
        drive_f(1, 10, 20, 5, 1'b1);
        push_pix(10, 20, 5);
        push_done();
        @(negedge CLOCK_50);
        chk("fp_grant_clear", int'(grant_f), 0);
        chk("fp_busy_clear", int'(busy_f), 0);
        idle_f();
        req_f = 5'b10100;
        @(negedge CLOCK_50);
        chk("fp_grant2", int'(grant_f), 5'b00100);
        chk("hold_x", int'(x_f), 10);
        chk("hold_y", int'(y_f), 20);
        chk("idle_colour", int'(colour_f), 7);

        // Clipping at the right edge on ch2
        for (int k = 0; k < 4; k++) begin
            drive_f(2, 318 + k, 5, k + 1, k == 3);
            if (318 + k <= 319) push_pix(318 + k, 5, k + 1);
            if (k == 3) push_done();
            @(negedge CLOCK_50);
        end
        idle_f();
        req_f = 5'b10000;
        @(negedge CLOCK_50);
        chk("fp_grant4", int'(grant_f), 5'b10000);

        // ch4 aborts after two pixels; the pixel alongside the drop is discarded
        for (int k = 0; k < 2; k++) begin
            drive_f(4, 30 + k, 40, 4, 1'b0);
            push_pix(30 + k, 40, 4);
            @(negedge CLOCK_50);
        end
        drive_f(4, 50, 40, 6, 1'b0);
        req_f = '0;
        @(negedge CLOCK_50);
        chk("abort_grant", int'(grant_f), 0);
        chk("abort_busy", int'(busy_f), 0);
        idle_f();
        @(negedge CLOCK_50);
        chk("abort_stay_idle", int'(busy_f), 0);

        // Timeout: ch0 stalls, ch3 waits
        req_f = 5'b01001;
        @(negedge CLOCK_50);
        chk("to_grant0", int'(grant_f), 5'b00001);
        chk("to_terr_before", int'(terr_f), 0);
        repeat (7) @(negedge CLOCK_50);
        chk("to_still_owner", int'(grant_f), 5'b00001);
        chk("to_terr_pending", int'(terr_f), 0);
        @(negedge CLOCK_50);
        chk("to_released", int'(grant_f), 0);
        chk("to_terr_set", int'(terr_f), 1);
        req_f = 5'b01000;
        @(negedge CLOCK_50);
        chk("to_grant3", int'(grant_f), 5'b01000);

        // Reset mid-burst while a pixel is on the output and another is pending
        drive_f(3, 100, 100, 2, 1'b0);
        push_pix(100, 100, 2);
        @(negedge CLOCK_50);
        chk("terr_sticky", int'(terr_f), 1);
        drive_f(3, 101, 100, 3, 1'b0);
        #2 resetn = 1'b0;
        #1 chk_reset("async_rst");
        idle_f();
        req_f = '0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("post_rst_plot", int'(plot_f), 0);
        chk("post_rst_busy", int'(busy_f), 0);

        // Round-robin: all channels request, each sends a single last pixel
        foreach (exp_rr[i]) exp_rr.delete(i);
        for (int i = 0; i < 6; i++) exp_rr.push_back(i % 5);
        req_r = 5'b11111;
        for (int b = 0; b < 6; b++) begin
            n = 0;
            while (grant_r == 0 && n < 10) begin
                @(negedge CLOCK_50);
                n++;
            end
            if (grant_r == 0) chk("rr_wait_grant", n, -1);
            pix_valid_r = grant_r;
            pix_last_r  = grant_r;
            @(negedge CLOCK_50);
            pix_valid_r = '0;
            pix_last_r  = '0;
            if (b == 5) req_r = '0;
        end
        repeat (3) @(negedge CLOCK_50);
        chk("rr_idle_end", int'(grant_r), 0);
        chk("fix_queue_empty", exp_q.size(), 0);
        chk("rr_queue_empty", exp_rr.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
